// File: rtl/sync_arm_ctrl.sv
// sync_arm_ctrl
//   Armable sync scheduler. After an arm command it waits for a trigger.
//   The trigger is an external sync rising edge or a software sync.
//   It then emits a one-clk sync_out pulse DELAY_LENGTH ce-cycles after
//   the trigger, and again every PERIOD ce-cycles after that.
//   While running, any later external edge that does not land on phase 0
//   raises the sticky align_err flag.
//
// Parameters
//   PERIOD        generated-sync period in ce cycles (>= 2)
//   DELAY_LENGTH  trigger-to-first-sync offset in ce cycles (1 .. PERIOD-1)
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   ce          clock enable; all state advances only when ce=1
//   arm         arm command
//   disarm      return-to-idle command
//   sw_sync     software trigger (level)
//   ext_sync    external sync (rising-edge detected on ce cycles)
//   sync_out    registered sync pulse, one clk wide
//   armed       high while armed, waiting for a trigger
//   running     high while generating syncs
//   align_err   sticky external-sync misalignment flag
//   sync_count  sync_out pulses since last arm/reset (wraps)

module sync_arm_ctrl #(
  parameter int unsigned PERIOD       = 1024,
  parameter int unsigned DELAY_LENGTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        arm,
  input  logic        disarm,
  input  logic        sw_sync,
  input  logic        ext_sync,
  output logic        sync_out,
  output logic        armed,
  output logic        running,
  output logic        align_err,
  output logic [31:0] sync_count
);

  localparam int unsigned PW = $clog2(PERIOD);
  localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PH_DLY  = PW'(DELAY_LENGTH);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          ext_prev_q, ext_prev_d;
  logic          sync_out_q, sync_out_d;
  logic          err_q, err_d;
  logic [31:0]   cnt_q, cnt_d;

  logic          ext_rise;
  logic          trig;
  logic [PW-1:0] phase_inc;

  assign ext_rise  = ext_sync & ~ext_prev_q;
  assign trig      = ext_rise | sw_sync;
  assign phase_inc = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    ext_prev_d = ext_prev_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    sync_out_d = 1'b0;

    if (ce) begin
      ext_prev_d = ext_sync;
      unique case (state_q)
        S_IDLE: begin
          if (!disarm && arm) begin
            state_d = S_ARMED;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
        S_ARMED: begin
          if (disarm) begin
            state_d = S_IDLE;
          end else if (arm) begin
            cnt_d = '0;
            err_d = 1'b0;
          end else if (trig) begin
            // The trigger cycle itself counts as phase 0.
            state_d = S_RUN;
            phase_d = PH_ONE;
          end
        end
        S_RUN: begin
          if (disarm) begin
            state_d = S_IDLE;
            phase_d = '0;
          end else if (arm) begin
            state_d = S_ARMED;
            phase_d = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            phase_d = phase_inc;
            if (ext_rise && (phase_q != '0)) begin
              err_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      endcase

      // The pulse is set on the edge that reaches phase DELAY_LENGTH.
      // It is dropped on the next clk whether or not ce is high.
      if ((state_d == S_RUN) && (phase_d == PH_DLY)) begin
        sync_out_d = 1'b1;
        cnt_d      = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      ext_prev_q <= 1'b0;
      sync_out_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      ext_prev_q <= ext_prev_d;
      sync_out_q <= sync_out_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sync_out   = sync_out_q;
  assign armed      = (state_q == S_ARMED);
  assign running    = (state_q == S_RUN);
  assign align_err  = err_q;
  assign sync_count = cnt_q;

endmodule

// File: tb/tb_sync_arm_ctrl.sv
module tb_sync_arm_ctrl;

  localparam int unsigned P = 16;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst, ce, arm, disarm, sw_sync, ext_sync;
  logic        sync_out, armed, running, align_err;
  logic [31:0] sync_count;

  sync_arm_ctrl #(.PERIOD(P), .DELAY_LENGTH(D)) dut (
    .clk(clk), .rst(rst), .ce(ce), .arm(arm), .disarm(disarm),
    .sync_out(sync_out), .sw_sync(sw_sync), .ext_sync(ext_sync),
    .armed(armed), .running(running), .align_err(align_err),
    .sync_count(sync_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        so;
    logic        ar;
    logic        ru;
    logic        er;
    logic [31:0] cnt;
  } exp_t;

  exp_t scb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model. m_mode: 0 idle, 1 armed, 2 running.
  // m_n counts ce cycles elapsed since the trigger.
  int unsigned m_mode = 0;
  int unsigned m_n    = 0;
  logic        m_prev = 1'b0;
  logic        m_err  = 1'b0;
  logic [31:0] m_cnt  = '0;

  task automatic step(input logic r, input logic c, input logic a,
                      input logic d, input logic s, input logic e);
    exp_t x;
    logic so, rise, trig;
    rst = r; ce = c; arm = a; disarm = d; sw_sync = s; ext_sync = e;
    so = 1'b0;
    if (r) begin
      m_mode = 0; m_n = 0; m_prev = 1'b0; m_err = 1'b0; m_cnt = '0;
    end else if (c) begin
      rise   = e && !m_prev;
      trig   = rise || s;
      m_prev = e;
      case (m_mode)
        0: if (!d && a) begin m_mode = 1; m_cnt = '0; m_err = 1'b0; end
        1: begin
          if (d) m_mode = 0;
          else if (a) begin m_cnt = '0; m_err = 1'b0; end
          else if (trig) begin m_mode = 2; m_n = 1; end
        end
        default: begin
          if (d) m_mode = 0;
          else if (a) begin m_mode = 1; m_cnt = '0; m_err = 1'b0; end
          else begin
            if (rise && (m_n % P) != 0) m_err = 1'b1;
            m_n++;
          end
        end
      endcase
      if (m_mode == 2 && (m_n % P) == D) begin
        so = 1'b1;
        m_cnt++;
      end
    end
    x.so  = so;
    x.ar  = (m_mode == 1);
    x.ru  = (m_mode == 2);
    x.er  = m_err;
    x.cnt = m_cnt;
    @(posedge clk);
    #1;
    scb.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations at negedge.
  always @(negedge clk) begin
    exp_t x;
    if (scb.size() > 0) begin
      x = scb.pop_front();
      chk("sync_out",   {31'd0, sync_out},  {31'd0, x.so});
      chk("armed",      {31'd0, armed},     {31'd0, x.ar});
      chk("running",    {31'd0, running},   {31'd0, x.ru});
      chk("align_err",  {31'd0, align_err}, {31'd0, x.er});
      chk("sync_count", sync_count,         x.cnt);
    end
  end

  function automatic logic ext_pat(input int unsigned c);
    return (c >= 10 && c <= 12) || (c >= 26 && c <= 27) ||
           (c == 29) || (c >= 42 && c <= 43);
  endfunction

  initial begin
    logic ext_l;
    rst = 1'b1; ce = 1'b0; arm = 1'b0; disarm = 1'b0; sw_sync = 1'b0; ext_sync = 1'b0;

    // Reset held with random inputs, arm included.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom), 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));

    // Basic alignment, alignment check, re-arm (ce tied high).
    for (int unsigned c = 0; c < 52; c++)
      step(1'b0, 1'b1, (c == 2 || c == 50), 1'b0, 1'b0, ext_pat(c));

    // Gated ce, software trigger while armed.
    for (int unsigned c = 0; c < 70; c++)
      step(1'b0, (c % 2 == 0), 1'b0, 1'b0, (c == 2), 1'b0);

    // Priorities.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // arm from running
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);  // arm+sw in armed
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // disarm+arm -> idle
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // sw in idle
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // arm
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // trigger -> phase 1
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // phase 2
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // phase 3
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // disarm at phase 3
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the cycle before an expected pulse, then restart.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    ext_l = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) ext_l = ~ext_l;
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 119) == 0),
           ($urandom_range(0, 29) == 0),
           ext_l);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", scb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
